// File: rtl/flash_fetch_prefetcher_pkg.sv
// Shared definitions for the Flash fetch prefetcher: widths, FSM encoding,
// FIFO entry layout and address helpers.
package flash_prefetch_defs;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] WORD_STRIDE = 24'd4;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_STREAM = 2'd1,
        STATE_FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic              error;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/flash_fetch_prefetcher_fifo.sv
// Synchronous FIFO of prefetched {error, data} words with occupancy count,
// same-cycle push/pop and a flush input that empties it.
module prefetch_fifo
    import flash_prefetch_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  entry_t           wdata_i,
    input  logic             pop_i,
    output entry_t           rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: the storage array is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/flash_fetch_prefetcher.sv
// Read-only Wishbone pipelined master that serves single-word instruction
// fetches from a sequential prefetch stream, restarting it on any branch.
module flash_fetch_prefetcher
    import flash_prefetch_defs::*;
#(
    parameter int PREFETCH_DEPTH = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_error,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i,
    input  logic              wb_error_i,
    input  logic              wb_stall_i
);

    localparam int                CNT_W     = $clog2(PREFETCH_DEPTH + 1);
    localparam int                SUM_W     = CNT_W + 1;
    localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(PREFETCH_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic              head_known_q, head_known_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              stream_stop_q, stream_stop_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    entry_t            resp_q, resp_d;

    logic              accept, hit, miss;
    logic              resp_in, resp_keep, want;
    logic              take_fifo, take_bypass;
    logic              issue, eligible, eligible_d;
    logic              fifo_push, fifo_pop;
    logic [CNT_W-1:0]  fifo_count, fifo_count_d;
    entry_t            fifo_rdata, resp_entry, taken;

    prefetch_fifo #(
        .DEPTH (PREFETCH_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clear_i (miss),
        .push_i  (fifo_push),
        .wdata_i (resp_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    // Strobe eligibility uses registered state only, so the bus outputs carry no input paths.
    assign eligible = head_known_q && !stream_stop_q
                   && (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_SUM);

    assign wb_stb_o    = (state_q == STATE_STREAM) && eligible;
    assign wb_cyc_o    = wb_stb_o || (outstanding_q != '0);
    assign wb_we_o     = 1'b0;
    assign wb_sel_o    = 4'hF;
    assign wb_adr_o    = issue_addr_q;
    assign fetch_ready = !pend_q && (state_q != STATE_FLUSH);
    assign fetch_valid = valid_q;
    assign fetch_data  = resp_q.data;
    assign fetch_error = resp_q.error;

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        accept      = fetch_req && fetch_ready;
        hit         = head_known_q && (fetch_addr[ADDR_W-1:2] == head_addr_q[ADDR_W-1:2]);
        miss        = accept && !hit;
        issue       = wb_stb_o && !wb_stall_i;

        // Responses in the miss cycle or during FLUSH belong to the abandoned stream.
        resp_in     = (wb_ack_i || wb_error_i) && (outstanding_q != '0);
        resp_keep   = resp_in && (state_q != STATE_FLUSH) && !miss;
        resp_entry.error = wb_error_i;
        resp_entry.data  = wb_error_i ? '0 : wb_data_i;

        want        = (pend_q || accept) && !miss;
        take_fifo   = want && (fifo_count != '0);
        take_bypass = want && (fifo_count == '0) && resp_keep;
        fifo_pop    = take_fifo;
        fifo_push   = resp_keep && !take_bypass;
        taken       = take_fifo ? fifo_rdata : resp_entry;

        pend_d        = (pend_q || accept) && !(take_fifo || take_bypass);
        valid_d       = take_fifo || take_bypass;
        resp_d        = valid_d ? taken : resp_q;
        head_addr_d   = head_addr_q;
        head_known_d  = head_known_q;
        issue_addr_d  = issue ? issue_addr_q + WORD_STRIDE : issue_addr_q;
        stream_stop_d = stream_stop_q;
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp_in);
        fifo_count_d  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

        if (miss) begin
            head_addr_d   = word_align(fetch_addr);
            issue_addr_d  = word_align(fetch_addr);
            head_known_d  = 1'b1;
            stream_stop_d = 1'b0;
            fifo_count_d  = '0;
        end else begin
            if (valid_d) begin
                head_addr_d = head_addr_q + WORD_STRIDE;
                if (taken.error) head_known_d = 1'b0;
            end
            if (resp_keep && wb_error_i) stream_stop_d = 1'b1;
        end

        eligible_d = head_known_d && !stream_stop_d
                  && (({1'b0, outstanding_d} + {1'b0, fifo_count_d}) < DEPTH_SUM);

        state_d = state_q;
        if (miss && (outstanding_d != '0)) begin
            state_d = STATE_FLUSH;
        end else if (state_q == STATE_FLUSH && outstanding_d != '0) begin
            state_d = STATE_FLUSH;
        end else if (eligible_d || (outstanding_d != '0)) begin
            state_d = STATE_STREAM;
        end else begin
            state_d = STATE_IDLE;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= STATE_IDLE;
            head_addr_q   <= '0;
            head_known_q  <= 1'b0;
            issue_addr_q  <= '0;
            outstanding_q <= '0;
            stream_stop_q <= 1'b0;
            pend_q        <= 1'b0;
            valid_q       <= 1'b0;
            resp_q        <= '0;
        end else begin
            state_q       <= state_d;
            head_addr_q   <= head_addr_d;
            head_known_q  <= head_known_d;
            issue_addr_q  <= issue_addr_d;
            outstanding_q <= outstanding_d;
            stream_stop_q <= stream_stop_d;
            pend_q        <= pend_d;
            valid_q       <= valid_d;
            resp_q        <= resp_d;
        end
    end

endmodule

// File: tb/tb_flash_fetch_prefetcher.sv
// Scoreboard bench: the driver queues expected responses, a monitor pops them
// on fetch_valid, and a pipelined Flash slave model with latency 3 answers reads.
module tb_flash_fetch_prefetcher;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        fetch_req = 1'b0;
    logic [23:0] fetch_addr = '0;
    logic        fetch_ready, fetch_valid, fetch_error;
    logic [31:0] fetch_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [23:0] wb_adr_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0, wb_error_i = 1'b0, wb_stall_i = 1'b0;

    flash_fetch_prefetcher #(.PREFETCH_DEPTH(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_error (fetch_error),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i),
        .wb_error_i  (wb_error_i),
        .wb_stall_i  (wb_stall_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [23:0] adr;
        int          due;
    } sreq_t;

    exp_t        exp_q [$];
    sreq_t       slv_q [$];
    logic [23:0] adr_log [$];
    logic [23:0] err_adr = 24'h0ABCDE;
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Slave: accepted strobe in cycle c is answered in cycle c+LAT; data = {C0, address}.
    initial begin
        sreq_t r;
        forever begin
            @(posedge clk);
            #1;
            wb_ack_i   = 1'b0;
            wb_error_i = 1'b0;
            wb_data_i  = '0;
            if (slv_q.size() > 0 && slv_q[0].due <= cyc_cnt) begin
                r = slv_q.pop_front();
                if (r.adr == err_adr) begin
                    wb_error_i = 1'b1;
                    wb_data_i  = 32'hDEAD_BEEF;
                end else begin
                    wb_ack_i  = 1'b1;
                    wb_data_i = {8'hC0, r.adr};
                end
            end
            @(negedge clk);
            if (!wb_rst_i && wb_cyc_o && wb_stb_o && !wb_stall_i) begin
                slv_q.push_back('{adr: wb_adr_o, due: cyc_cnt + LAT});
                adr_log.push_back(wb_adr_o);
            end
        end
    end

    // Monitor: compare every response against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!wb_rst_i && fetch_valid) begin
                check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp_data", fetch_data, e.data);
                    check("resp_error", 32'(fetch_error), 32'(e.err));
                    if (e.lat >= 0) check("resp_latency", 32'(cyc_cnt - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic fetch(input logic [23:0] a, input logic [31:0] d, input logic e, input int lat);
        int waited = 0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        while (!fetch_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!fetch_ready) begin
            check("ready_wait", 32'(fetch_ready), 32'd1);
            fetch_req = 1'b0;
            return;
        end
        exp_q.push_back('{data: d, err: e, lat: lat, acc: cyc_cnt});
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    task automatic quiet(input int idle);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (idle) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int n, input logic [23:0] a0, input logic [23:0] a1,
                             input logic [23:0] a2, input logic [23:0] a3,
                             input logic [23:0] a4, input logic [23:0] a5);
        logic [23:0] want [6];
        want = '{a0, a1, a2, a3, a4, a5};
        check("adr_log_len", 32'(adr_log.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i < adr_log.size()) check($sformatf("adr_log[%0d]", i), 32'(adr_log[i]), 32'(want[i]));
        end
        adr_log.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
        check({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
        check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        check({tag, "_data"}, fetch_data, 32'd0);
        check({tag, "_err"}, 32'(fetch_error), 32'd0);
        check({tag, "_adr"}, 32'(wb_adr_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 wb_rst_i = 1'b1;
        #1 check_idle_outputs("reset");
        check("reset_we", 32'(wb_we_o), 32'd0);
        check("reset_sel", 32'(wb_sel_o), 32'hF);
        @(negedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, two buffered sequential hits, then a branch with two reads in flight.
        fetch(24'h000100, 32'hC000_0100, 1'b0, 5);
        repeat (8) @(posedge clk);
        #1;
        fetch(24'h000106, 32'hC000_0104, 1'b0, 1);
        fetch(24'h000108, 32'hC000_0108, 1'b0, 1);
        fetch(24'h002000, 32'hC000_2000, 1'b0, 8);
        quiet(8);
        check_log(6, 24'h000100, 24'h000104, 24'h000108, 24'h00010C, 24'h000110, 24'h002000);

        // Bus error on 0x104: error response with zero data, stream stops, 0x108 re-read.
        err_adr = 24'h000104;
        fetch(24'h000100, 32'hC000_0100, 1'b0, 5);
        fetch(24'h000104, 32'h0000_0000, 1'b1, 1);
        fetch(24'h000108, 32'hC000_0108, 1'b0, 7);
        quiet(8);
        err_adr = 24'h0ABCDE;
        check_log(4, 24'h000100, 24'h000104, 24'h000108, 24'h000108, 24'h0, 24'h0);

        // Stall held for four strobe cycles: address must hold, order preserved.
        wb_stall_i = 1'b1;
        fetch(24'h000400, 32'hC000_0400, 1'b0, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_adr", 32'(wb_adr_o), 32'h0000_0400);
            check("stall_stb", 32'(wb_stb_o), 32'd1);
        end
        @(posedge clk);
        #1 wb_stall_i = 1'b0;
        fetch(24'h000404, 32'hC000_0404, 1'b0, -1);
        fetch(24'h000408, 32'hC000_0408, 1'b0, -1);
        quiet(8);
        check_log(3, 24'h000400, 24'h000404, 24'h000408, 24'h0, 24'h0, 24'h0);

        // Address wrap at the top of the 24-bit window.
        fetch(24'hFFFFF8, 32'hC0FF_FFF8, 1'b0, 5);
        fetch(24'hFFFFFC, 32'hC0FF_FFFC, 1'b0, 1);
        fetch(24'h000000, 32'hC000_0000, 1'b0, 3);
        quiet(8);
        check_log(3, 24'hFFFFF8, 24'hFFFFFC, 24'h000000, 24'h0, 24'h0, 24'h0);

        // Asynchronous reset with reads in flight; late acks must be ignored.
        fetch(24'h000500, 32'hC000_0500, 1'b0, -1);
        @(negedge clk);
        check("pre_reset_cyc", 32'(wb_cyc_o), 32'd1);
        #2 wb_rst_i = 1'b1;
        exp_q.delete();
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_cyc", 32'(wb_cyc_o), 32'd0);
        adr_log.delete();
        fetch(24'h000600, 32'hC000_0600, 1'b0, 5);
        quiet(4);
        check_log(1, 24'h000600, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
